// File: rtl/pulse_meter_pkg.sv
// Pulse period meter shared types.
// FSM states and match-counter width.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURING
  } state_t;

  localparam int MATCH_W = 4;

endpackage

// File: rtl/rising_edge_detector.sv
// Rising-edge detector for a clk-synchronous input.
// out is high when in is high and was low last cycle.
module rising_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  logic in_q;

  // Previous-cycle sample of in, kept running regardless of enable.
  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in;
  end

  assign out = in & ~in_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures spacing between rising edges of in.
// Reports period, lock status and timeout.
import pulse_meter_pkg::*;

module pulse_period_meter #(
  parameter int N          = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in,
  output logic [N-1:0] period,
  output logic         valid,
  output logic         locked,
  output logic         timeout
);

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = N'(1);
  localparam logic [MATCH_W-1:0] LOCK_M =
    MATCH_W'(LOCK_COUNT);
  localparam logic [MATCH_W-1:0] M_ONE =
    MATCH_W'(1);

  state_t state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] period_q, period_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic valid_q, valid_d;
  logic timeout_q, timeout_d;
  logic ev;

  rising_edge_detector u_edge (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (ev)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, counter and registered-output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    match_d   = match_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
      match_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARMED;
          cnt_d   = '0;
        end
        ARMED: begin
          if (ev) begin
            state_d = MEASURING;
            cnt_d   = CNT_ONE;
          end
        end
        MEASURING: begin
          if (ev) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
            if (cnt_q != period_q)
              match_d = M_ONE;
            else if (match_q < LOCK_M)
              match_d = match_q + M_ONE;
            else
              match_d = LOCK_M;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            state_d   = ARMED;
            cnt_d     = '0;
            match_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Datapath and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      period_q  <= '0;
      match_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      match_q   <= match_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign locked  = (match_q == LOCK_M);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter.
// Directed vector table plus hand-written corner sequences.
module tb_pulse_period_meter;

  localparam int N  = 8;
  localparam int LC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  logic in  = 1'b0;
  logic [N-1:0] period;
  logic valid, locked, timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int spacing;
    int width;
    int npulses;
    int exp_period;
    int exp_valids;
    int exp_locked;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  pulse_period_meter #(.N(N), .LOCK_COUNT(LC)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .in      (in),
    .period  (period),
    .valid   (valid),
    .locked  (locked),
    .timeout (timeout)
  );

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick(input logic e, input logic i);
    ena = e;
    in  = i;
    @(posedge clk);
    #1;
    checks++;
    if (valid && timeout) begin
      errors++;
      $display("FAIL strobe_overlap: valid=%0d timeout=%0d, expected not both high",
               valid, timeout);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic arm();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  initial begin
    int nv, nto, tk, bad;
    int gaps[10];
    int expl[10];

    vecs[0] = '{5, 1, 6, 5, 5, 1};
    vecs[1] = '{2, 1, 4, 2, 3, 0};
    vecs[2] = '{10, 3, 5, 10, 4, 1};
    vecs[3] = '{255, 1, 3, 255, 2, 0};
    vecs[4] = '{7, 2, 5, 7, 4, 1};
    vecs[5] = '{3, 1, 3, 3, 2, 0};

    gaps = '{5, 5, 5, 5, 5, 7, 5, 5, 5, 5};
    expl = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 1};

    // reset state, with ena and in driven high
    do_reset();
    chk("rst_period", period, 0);
    chk("rst_valid", valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", timeout, 0);

    // table-driven pulse trains
    for (int v = 0; v < 6; v++) begin
      do_reset();
      arm();
      nv = 0;
      nto = 0;
      for (int p = 0; p < vecs[v].npulses; p++) begin
        for (int c = 0; c < vecs[v].spacing; c++) begin
          tick(1'b1, c < vecs[v].width);
          if (valid) begin
            nv++;
            chk($sformatf("vec%0d_period", v), period,
                vecs[v].exp_period);
          end
          if (timeout) nto++;
        end
      end
      chk($sformatf("vec%0d_valids", v), nv,
          vecs[v].exp_valids);
      chk($sformatf("vec%0d_timeouts", v), nto, 0);
      chk($sformatf("vec%0d_locked", v), locked,
          vecs[v].exp_locked);
    end

    // lock, break with gap 7, relock
    do_reset();
    arm();
    tick(1'b1, 1'b1);
    chk("first_event_valid", valid, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 1; c < gaps[i]; c++) begin
        tick(1'b1, 1'b0);
        if (valid || timeout) bad++;
      end
      tick(1'b1, 1'b1);
      chk($sformatf("lock%0d_valid", i), valid, 1);
      chk($sformatf("lock%0d_period", i), period, gaps[i]);
      chk($sformatf("lock%0d_locked", i), locked, expl[i]);
    end
    chk("lock_spurious_strobe", bad, 0);

    // ena drop while locked
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("ena_drop_locked", locked, 0);
    chk("ena_drop_valid", valid, 0);
    chk("ena_drop_timeout", timeout, 0);
    chk("ena_drop_period", period, 5);

    // re-enable with in already high
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      if (valid || timeout) bad++;
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      if (valid || timeout) bad++;
    end
    tick(1'b1, 1'b0);
    if (valid || timeout) bad++;
    chk("reenable_quiet", bad, 0);
    tick(1'b1, 1'b1);
    chk("reenable_first_event", valid, 0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("reenable_valid", valid, 1);
    chk("reenable_period", period, 4);
    chk("reenable_locked", locked, 0);

    // lock at 4, then reset mid-period
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
    end
    chk("p4_locked", locked, 1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b0);
    rst = 1'b0;
    chk("midrst_locked", locked, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_timeout", timeout, 0);
    chk("midrst_period", period, 0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b0);
      if (valid || timeout) bad++;
    end
    chk("midrst_no_strobe", bad, 0);

    // timeout after a single pulse
    do_reset();
    arm();
    tick(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("to_pre_valid", valid, 1);
    chk("to_pre_period", period, 6);
    nv = 0;
    nto = 0;
    tk = -1;
    for (int k = 1; k <= 300; k++) begin
      tick(1'b1, 1'b0);
      if (valid) nv++;
      if (timeout) begin
        nto++;
        if (tk < 0) tk = k;
      end
    end
    chk("to_count", nto, 1);
    chk("to_cycle", tk, 255);
    chk("to_valids", nv, 0);
    chk("to_period_kept", period, 6);
    chk("to_locked", locked, 0);
    tick(1'b1, 1'b1);
    chk("to_rearm_first", valid, 0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("to_rearm_valid", valid, 1);
    chk("to_rearm_period", period, 6);

    // in constantly high
    do_reset();
    arm();
    nv = 0;
    nto = 0;
    tk = -1;
    for (int k = 1; k <= 300; k++) begin
      tick(1'b1, 1'b1);
      if (valid) nv++;
      if (timeout) begin
        nto++;
        if (tk < 0) tk = k;
      end
    end
    chk("high_valids", nv, 0);
    chk("high_timeouts", nto, 1);
    chk("high_to_cycle", tk, 256);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
